// File: rtl/keypad_matrix_scanner_if.sv
// rtl/keypad_matrix_scanner_if.sv - key event handshake between scanner and consumer
interface keypad_matrix_scanner_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] encout;
    logic              key_valid;
    logic              key_ready;
    logic              multi_key;
    logic              key_held;

    modport master (
        output encout,
        output key_valid,
        output multi_key,
        output key_held,
        input  key_ready
    );

    modport slave (
        input  encout,
        input  key_valid,
        input  multi_key,
        input  key_held,
        output key_ready
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - debounced ROWS x COLS keypad scanner with ghost detection
module keypad_matrix_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  colsel,
    keypad_matrix_scanner_if.master evt
);
    localparam int KEYS    = ROWS * COLS;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DWELL_W = $clog2(SETTLE_CYCLES + 1);
    localparam int COL_W   = $clog2(COLS);
    localparam logic [COLS-1:0] ONE = COLS'(1);

    typedef enum logic [2:0] {IDLE, SCAN, EVAL, REPORT, HOLD} state_t;

    state_t            state;
    logic [ROWS-1:0]   row_m;
    logic [ROWS-1:0]   row_s;
    logic [CNT_W-1:0]  cnt;
    logic [DWELL_W-1:0] dwell;
    logic [COL_W-1:0]  col;
    logic [1:0]        hits;
    logic [KEYS-1:0]   snap;
    logic [2:0]        hits_sum;
    logic              any_row;

    function automatic logic [1:0] row_hits(input logic [ROWS-1:0] r);
        int n;
        n = 0;
        for (int i = 0; i < ROWS; i++) n = n + int'(r[i]);
        return (n >= 2) ? 2'd2 : 2'(n);
    endfunction

    // Only meaningful when exactly one snapshot bit is set.
    function automatic logic [CODE_W-1:0] first_key(input logic [KEYS-1:0] s);
        logic [CODE_W-1:0] k;
        k = '0;
        for (int i = KEYS - 1; i >= 0; i--) if (s[i]) k = CODE_W'(i);
        return k;
    endfunction

    assign any_row  = |row_s;
    assign hits_sum = {1'b0, hits} + {1'b0, row_hits(row_s)};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            row_m         <= '0;
            row_s         <= '0;
            cnt           <= '0;
            dwell         <= '0;
            col           <= '0;
            hits          <= '0;
            snap          <= '0;
            colsel        <= '1;
            evt.encout    <= '0;
            evt.key_valid <= 1'b0;
            evt.multi_key <= 1'b0;
            evt.key_held  <= 1'b0;
        end else begin
            row_m         <= row_in;
            row_s         <= row_m;
            evt.multi_key <= 1'b0;
            case (state)
                IDLE: begin
                    colsel <= '1;
                    if (!any_row) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        cnt    <= '0;
                        dwell  <= '0;
                        col    <= '0;
                        hits   <= '0;
                        snap   <= '0;
                        colsel <= ONE;
                        state  <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCAN: begin
                    // The last dwell cycle is the first one where row_s reflects this column.
                    if (dwell == DWELL_W'(SETTLE_CYCLES - 1)) begin
                        for (int r = 0; r < ROWS; r++) snap[r*COLS + int'(col)] <= row_s[r];
                        hits  <= (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
                        dwell <= '0;
                        if (col == COL_W'(COLS - 1)) begin
                            colsel <= '1;
                            state  <= EVAL;
                        end else begin
                            col    <= col + 1'b1;
                            colsel <= ONE << (col + 1'b1);
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                EVAL: begin
                    colsel <= '1;
                    cnt    <= '0;
                    if (hits == 2'd0) begin
                        state <= IDLE;
                    end else if (hits == 2'd1) begin
                        evt.encout    <= first_key(snap);
                        evt.key_valid <= 1'b1;
                        state         <= REPORT;
                    end else begin
                        evt.multi_key <= 1'b1;
                        evt.key_held  <= 1'b1;
                        state         <= HOLD;
                    end
                end
                REPORT: begin
                    colsel <= '1;
                    if (evt.key_ready) begin
                        evt.key_valid <= 1'b0;
                        evt.key_held  <= 1'b1;
                        cnt           <= '0;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    colsel <= '1;
                    if (any_row) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        cnt          <= '0;
                        evt.key_held <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - randomized self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pressed = '0;
    logic [15:0] pressed2 = '0;
    logic [3:0]  row_in;
    logic [3:0]  colsel;
    logic [1:0]  row_in2;
    logic [7:0]  colsel2;

    int errors = 0;
    int checks = 0;
    int xfers = 0;
    int multis = 0;
    int last_code = 0;
    int xfers2 = 0;

    always #5 clock = ~clock;

    keypad_matrix_scanner_if #(.CODE_W(4)) kif ();
    keypad_matrix_scanner_if #(.CODE_W(4)) kif2 ();

    keypad_matrix_scanner dut (
        .clock  (clock),
        .reset  (reset),
        .row_in (row_in),
        .colsel (colsel),
        .evt    (kif)
    );

    keypad_matrix_scanner #(.ROWS(2), .COLS(8), .CODE_W(4)) dut2 (
        .clock  (clock),
        .reset  (reset),
        .row_in (row_in2),
        .colsel (colsel2),
        .evt    (kif2)
    );

    // Ideal switch matrix: a row conducts when a pressed key sits on a driven column.
    always_comb begin
        row_in  = '0;
        row_in2 = '0;
        for (int r = 0; r < 4; r++) row_in[r] = |(colsel & pressed[r*4 +: 4]);
        for (int r = 0; r < 2; r++) row_in2[r] = |(colsel2 & pressed2[r*8 +: 8]);
    end

    always @(negedge clock) begin
        if (reset) begin
            if (kif.key_valid && kif.key_ready) begin
                xfers++;
                last_code = int'(kif.encout);
            end
            if (kif.multi_key) multis++;
            if (kif2.key_valid && kif2.key_ready) xfers2++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // -1: nothing pressed, -2: ghost/multi press, else the key index.
    function automatic int ref_code(input logic [15:0] k);
        if ($countones(k) == 0) return -1;
        if ($countones(k) > 1) return -2;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic do_press(input logic [15:0] keys, input int ready_wait, input int hold);
        int exp, n, x0, m0, stable;
        logic [3:0] code0;
        exp = ref_code(keys);
        x0 = xfers;
        m0 = multis;
        @(posedge clock); #1;
        kif.key_ready = (ready_wait == 0);
        pressed = keys;
        n = 0;
        while (!(kif.key_valid || kif.multi_key) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (exp >= 0) begin
            check("press_latency", (n >= 18 && n <= 20), 1);
            check("key_valid", kif.key_valid, 1);
            check("encout", kif.encout, exp);
            code0 = kif.encout;
            stable = 1;
            for (int i = 0; i < ready_wait; i++) begin
                @(negedge clock);
                if (!kif.key_valid || kif.encout !== code0) stable = 0;
                if (i == ready_wait / 2) pressed = '0;
            end
            if (ready_wait > 0) begin
                check("report_stable", stable, 1);
                @(posedge clock); #1;
                kif.key_ready = 1'b1;
            end
            @(posedge clock); #1;
            check("valid_drop", kif.key_valid, 0);
            check("held_after_xfer", kif.key_held, 1);
        end else begin
            check("multi_pulse", kif.multi_key, 1);
            check("valid_on_multi", kif.key_valid, 0);
            @(negedge clock);
            check("multi_one_cycle", kif.multi_key, 0);
            check("held_on_multi", kif.key_held, 1);
        end
        tick(hold);
        pressed = '0;
        n = 0;
        while (kif.key_held && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (ready_wait == 0) check("release_debounce", (n >= 6 && n <= 8), 1);
        else check("held_clear", kif.key_held, 0);
        tick(3);
        check("xfer_count", xfers - x0, (exp >= 0) ? 1 : 0);
        check("multi_count", multis - m0, (exp == -2) ? 1 : 0);
        if (exp >= 0) check("xfer_code", last_code, exp);
    endtask

    initial begin
        int x0, m0, n, flag;
        logic [15:0] keys;
        kif.key_ready  = 1'b0;
        kif2.key_ready = 1'b0;

        reset = 1'b0;
        tick(2);
        check("rst_colsel", colsel, 4'hF);
        check("rst_valid", kif.key_valid, 0);
        check("rst_encout", kif.encout, 0);
        check("rst_held", kif.key_held, 0);
        check("rst_multi", kif.multi_key, 0);
        check("rst_colsel2", colsel2, 8'hFF);
        reset = 1'b1;
        tick(2);

        // 2x8 geometry: row1/col7 encodes as 15.
        kif2.key_ready = 1'b1;
        pressed2 = 16'h8000;
        n = 0;
        while (!kif2.key_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("wide_valid", kif2.key_valid, 1);
        check("wide_encout", kif2.encout, 15);
        tick(5);
        pressed2 = '0;
        tick(15);
        check("wide_xfers", xfers2, 1);

        do_press(16'h0040, 0, 5);

        x0 = xfers;
        for (int k = 0; k < 16; k++) do_press(16'(1) << k, 0, 3);
        check("sweep_count", xfers - x0, 16);

        do_press(16'h8000, 30, 2);

        do_press(16'h0021, 0, 3);

        // Short bounce: never reaches a scan.
        x0 = xfers;
        m0 = multis;
        pressed = 16'h0020;
        tick(3);
        pressed = '0;
        flag = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (colsel !== 4'hF) flag = 1;
        end
        check("bounce_no_scan", flag, 0);
        check("bounce_no_xfer", xfers - x0, 0);

        // Debounced but released before its column is scanned.
        pressed = 16'h0008;
        tick(7);
        pressed = '0;
        flag = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (colsel !== 4'hF) flag = 1;
        end
        check("late_release_scanned", flag, 1);
        check("late_release_no_xfer", xfers - x0, 0);
        check("late_release_no_multi", multis - m0, 0);
        check("late_release_idle", colsel, 4'hF);
        check("late_release_held", kif.key_held, 0);

        // Reset in the middle of a scan.
        pressed = 16'h0200;
        tick(10);
        reset = 1'b0;
        tick(1);
        check("midrst_colsel", colsel, 4'hF);
        check("midrst_valid", kif.key_valid, 0);
        check("midrst_encout", kif.encout, 0);
        check("midrst_held", kif.key_held, 0);
        pressed = '0;
        tick(2);
        reset = 1'b1;
        tick(40);
        check("midrst_no_xfer", xfers - x0, 0);

        for (int it = 0; it < 24; it++) begin
            keys = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) keys = keys | (16'(1) << $urandom_range(0, 15));
            do_press(keys, $urandom_range(0, 4), $urandom_range(1, 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
